spi_reg_ctrlr: RTL and testbench

//  Command/register controller sequencing the SPI slave byte stream. Parses each
//  ss-framed transfer as CMD byte + data bytes. Performs reads/writes on a small

---
 rtl/spi_reg_ctrlr.sv | 175 +++++++++++++++++
 tb/tb_spi_reg_ctrlr.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrlr.sv
// spi_reg_ctrlr
//   Command/register controller behind an SPI slave. Each ss-framed transfer is a
//   CMD byte followed by data bytes. CMD[7] selects write (1) or read (0) and
//   CMD[ADDR_W-1:0] is the start address. The address auto-increments and wraps.
//   dout is the byte the SPI slave shifts out on the next transfer.
//
//   Register map: 0 LED[7:0] RW, 1 LED[15:8] RW, 2 SW[7:0] RO, 3 SW[15:8] RO,
//                 4 SCRATCH RW, 5 STATUS RO {frame_err,3'b0,byte_cnt}, 6 ID RO,
//                 7+ reserved (reads 0, writes ignored).
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   ss        slave select, active-low (frame = ss low)
//   new_data  1-cycle pulse, din holds a received byte
//   din       received byte
//   dout      next byte to transmit
//   switches  board switches (read at the edge that services the byte)
//   leds      board LEDs, {reg1, reg0}
//   frame_err sticky flag set by writes to read-only/reserved addresses
module spi_reg_ctrlr #(
  parameter logic [7:0] ID_VALUE = 8'hA5,
  parameter int         ADDR_W   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ss,
  input  logic        new_data,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic [15:0] switches,
  output logic [15:0] leds,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [3:0]        byte_cnt_reg, byte_cnt_next;
  logic [7:0]        dout_reg, dout_next;
  logic [7:0]        scratch_reg;
  logic              frame_err_reg;
  // Cleared by reset; a frame may only start after ss has been seen high,
  // so a reset in the middle of a frame does not resume that frame.
  logic              armed_reg, armed_next;

  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_idx, wr_idx, rd_data;
  logic [3:0]        cnt_inc;
  logic              wr_en, wr_ok;

  // The CMD byte itself supplies the first read address.
  assign rd_addr = (state_reg == CMD) ? din[ADDR_W-1:0] : addr_reg;
  assign rd_idx  = 8'(rd_addr);
  assign wr_idx  = 8'(addr_reg);
  assign cnt_inc = (byte_cnt_reg == 4'hF) ? 4'hF : byte_cnt_reg + 4'd1;

  // A byte arriving together with ss rising is still serviced.
  assign wr_en = (state_reg == WR) && new_data;
  assign wr_ok = (wr_idx == 8'd0) || (wr_idx == 8'd1) || (wr_idx == 8'd4);

  always_comb begin
    rd_data = 8'h00;
    case (rd_idx)
      8'd0:    rd_data = leds[7:0];
      8'd1:    rd_data = leds[15:8];
      8'd2:    rd_data = switches[7:0];
      8'd3:    rd_data = switches[15:8];
      8'd4:    rd_data = scratch_reg;
      8'd5:    rd_data = {frame_err_reg, 3'b000, byte_cnt_reg};
      8'd6:    rd_data = ID_VALUE;
      default: rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    byte_cnt_next = byte_cnt_reg;
    dout_next     = dout_reg;
    armed_next    = armed_reg;
    case (state_reg)
      IDLE: begin
        dout_next = ID_VALUE;
        if (ss) begin
          armed_next = 1'b1;
        end else if (armed_reg) begin
          state_next    = CMD;
          byte_cnt_next = 4'd0;
        end
      end
      CMD: begin
        if (new_data) begin
          byte_cnt_next = cnt_inc;
          if (din[7]) begin
            state_next = WR;
            dout_next  = din;
            addr_next  = din[ADDR_W-1:0];
          end else begin
            state_next = RD;
            dout_next  = rd_data;
            addr_next  = din[ADDR_W-1:0] + 1'b1;
          end
        end
      end
      WR: begin
        if (new_data) begin
          byte_cnt_next = cnt_inc;
          dout_next     = din;
          addr_next     = addr_reg + 1'b1;
        end
      end
      RD: begin
        if (new_data) begin
          byte_cnt_next = cnt_inc;
          dout_next     = rd_data;
          addr_next     = addr_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // End of frame: return to IDLE; a coincident byte keeps its dout result.
    if ((state_reg != IDLE) && ss) begin
      state_next = IDLE;
      if (!new_data) begin
        dout_next = ID_VALUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      byte_cnt_reg  <= 4'd0;
      dout_reg      <= ID_VALUE;
      armed_reg     <= 1'b0;
      scratch_reg   <= 8'h00;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      byte_cnt_reg  <= byte_cnt_next;
      dout_reg      <= dout_next;
      armed_reg     <= armed_next;
      if (wr_en && (wr_idx == 8'd4)) begin
        scratch_reg <= din;
      end
      if (wr_en && !wr_ok) begin
        frame_err_reg <= 1'b1;
      end
    end
  end

  // One register per LED byte, at addresses 0 and 1.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_led
      logic [7:0] led_byte_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          led_byte_reg <= 8'h00;
        end else if (wr_en && (wr_idx == 8'(gi))) begin
          led_byte_reg <= din;
        end
      end
      assign leds[gi*8 +: 8] = led_byte_reg;
    end
  endgenerate

  assign dout      = dout_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_reg_ctrlr.sv
module tb_spi_reg_ctrlr;

  logic        clk = 1'b0;
  logic        rst;
  logic        ss;
  logic        new_data;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [15:0] switches;
  logic [15:0] leds;
  logic        frame_err;

  spi_reg_ctrlr #(.ID_VALUE(8'hA5), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .ss(ss), .new_data(new_data), .din(din),
    .dout(dout), .switches(switches), .leds(leds), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: register contents plus the position within the current frame.
  logic [15:0] m_leds;
  logic [7:0]  m_scratch;
  logic        m_ferr;
  int          m_cnt;
  int          m_pos;
  logic [2:0]  m_addr;
  logic        m_write;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] a);
    logic [3:0] c;
    c = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
    case (a)
      3'd0:    return m_leds[7:0];
      3'd1:    return m_leds[15:8];
      3'd2:    return switches[7:0];
      3'd3:    return switches[15:8];
      3'd4:    return m_scratch;
      3'd5:    return {m_ferr, 3'b000, c};
      3'd6:    return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_write(input logic [2:0] a, input logic [7:0] b);
    case (a)
      3'd0:    m_leds[7:0]  = b;
      3'd1:    m_leds[15:8] = b;
      3'd4:    m_scratch    = b;
      default: m_ferr       = 1'b1;
    endcase
  endtask

  task automatic model_reset();
    m_leds = 16'h0000; m_scratch = 8'h00; m_ferr = 1'b0;
    m_cnt = 0; m_pos = 0; m_addr = 3'd0; m_write = 1'b0;
  endtask

  task automatic check_regs(input string tag, input logic [7:0] exp_dout);
    check({tag, "_dout"}, 16'(dout), 16'(exp_dout));
    check({tag, "_leds"}, leds, m_leds);
    check({tag, "_ferr"}, 16'(frame_err), 16'(m_ferr));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); rst = 1'b1; new_data = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    $display("reset  %s: dout=%h leds=%h ferr=%b", tag, dout, leds, frame_err);
    check_regs(tag, 8'hA5);
  endtask

  task automatic start_frame(input string tag);
    @(negedge clk); ss = 1'b0;
    m_pos = 0; m_cnt = 0;
    @(negedge clk);
    check({tag, "_start"}, 16'(dout), 16'h00A5);
  endtask

  task automatic end_frame(input string tag);
    @(negedge clk); ss = 1'b1;
    @(negedge clk);
    check({tag, "_end"}, 16'(dout), 16'h00A5);
  endtask

  // Sends one byte of the current frame; rise=1 raises ss in the same cycle.
  task automatic send_byte(input logic [7:0] b, input logic rise, input string tag);
    logic [7:0] exp;
    if (m_pos == 0) begin
      m_addr  = b[2:0];
      m_write = b[7];
      if (m_write) begin
        exp = b;
      end else begin
        exp = model_read(m_addr);
        m_addr = m_addr + 3'd1;
      end
    end else if (m_write) begin
      exp = b;
      model_write(m_addr, b);
      m_addr = m_addr + 3'd1;
    end else begin
      exp = model_read(m_addr);
      m_addr = m_addr + 3'd1;
    end
    m_pos++;
    m_cnt++;
    @(negedge clk); din = b; new_data = 1'b1; if (rise) ss = 1'b1;
    @(negedge clk); new_data = 1'b0; din = 8'($urandom);
    $display("byte   %s: din=%h dout=%h exp=%h leds=%h ferr=%b", tag, b, dout, exp, leds, frame_err);
    check_regs(tag, exp);
    if (rise) begin
      @(negedge clk);
      check({tag, "_rise_idle"}, 16'(dout), 16'h00A5);
    end
  endtask

  // A byte the controller must not act on (ss high, or not re-armed after reset).
  task automatic send_ignored(input logic [7:0] b, input string tag);
    @(negedge clk); din = b; new_data = 1'b1;
    @(negedge clk); new_data = 1'b0;
    $display("ignore %s: din=%h dout=%h leds=%h ferr=%b", tag, b, dout, leds, frame_err);
    check_regs(tag, 8'hA5);
  endtask

  initial begin
    int nb;
    logic rise;
    logic [7:0] b;
    rst = 1'b1; ss = 1'b1; new_data = 1'b0; din = 8'h00; switches = 16'h0000;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_regs("reset", 8'hA5);

    // 1: single-byte frame; A5 presented before the first byte
    start_frame("t1");
    send_byte(8'h00, 1'b0, "t1_cmd");
    end_frame("t1");

    // 2: LED write
    start_frame("t2");
    send_byte(8'h80, 1'b0, "t2_cmd");
    send_byte(8'h34, 1'b0, "t2_d0");
    send_byte(8'h12, 1'b0, "t2_d1");
    end_frame("t2");
    check("t2_leds_1234", leds, 16'h1234);

    // 3: switch read
    switches = 16'hBEEF;
    start_frame("t3");
    send_byte(8'h02, 1'b0, "t3_cmd");
    send_byte(8'h00, 1'b0, "t3_d0");
    send_byte(8'h00, 1'b0, "t3_d1");
    end_frame("t3");

    // 4: read across the address wrap
    start_frame("t4");
    send_byte(8'h06, 1'b0, "t4_cmd");
    for (int k = 0; k < 3; k++) send_byte(8'hFF, 1'b0, "t4_d");
    end_frame("t4");

    // 5: write to read-only switches, then read STATUS
    start_frame("t5w");
    send_byte(8'h82, 1'b0, "t5_cmd");
    send_byte(8'h55, 1'b0, "t5_d0");
    end_frame("t5w");
    start_frame("t5r");
    send_byte(8'h05, 1'b0, "t5_status");
    end_frame("t5r");

    // bytes while ss high are ignored; empty frame leaves no error behind
    send_ignored(8'h81, "ss_high0");
    send_ignored(8'h7E, "ss_high1");
    start_frame("empty");
    end_frame("empty");

    // byte coincident with ss rising is serviced, then IDLE
    start_frame("rise");
    send_byte(8'h84, 1'b0, "rise_cmd");
    send_byte(8'hC3, 1'b1, "rise_d0");

    // 6: reset in the middle of a scratch write
    start_frame("t6");
    send_byte(8'h84, 1'b0, "t6_cmd");
    send_byte(8'h5A, 1'b0, "t6_d0");
    do_reset("t6_rst");
    send_ignored(8'h77, "t6_ign0");
    send_ignored(8'h81, "t6_ign1");
    end_frame("t6");
    start_frame("t6r");
    send_byte(8'h04, 1'b0, "t6_scratch");
    end_frame("t6r");

    // randomized frames against the model
    for (int f = 0; f < 60; f++) begin
      if (f == 30) do_reset("rand_rst");
      switches = 16'($urandom);
      start_frame("rand");
      nb   = $urandom_range(0, 20);
      rise = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom);
        // keep most writes on writable addresses so frame_err is not always set
        if (k == 0 && b[7] && $urandom_range(0, 3) != 0) b[2:0] = 3'd0;
        send_byte(b, rise && (k == nb - 1), "rand");
      end
      if (!(rise && nb > 0)) end_frame("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
